// File: rtl/remote_cmd_tx.sv
// Remote-side command transmitter: sends a 16-bit command as two back-to-back
// 8N1 UART frames, high byte first, and flags completion on cmd_sent.
module remote_cmd_tx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        TX,
    output logic        busy,
    output logic        cmd_sent
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND_HI,
        SEND_LO
    } state_t;

    state_t        state;
    logic [15:0]   cmd_hold;
    logic [8:0]    tx_shft;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic          baud_wrap;

    assign baud_wrap = (baud_cnt == BAUD_LAST);

    // TX is updated in the same cycle as tx_shft so the line is always the
    // registered copy of the bit being shifted out, with no extra latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd_hold <= '0;
            tx_shft  <= '1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            TX       <= 1'b1;
            busy     <= 1'b0;
            cmd_sent <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    TX <= 1'b1;
                    if (snd_cmd) begin
                        cmd_hold <= cmd;
                        tx_shft  <= {cmd[15:8], 1'b0};
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        cmd_sent <= 1'b0;
                        busy     <= 1'b1;
                        TX       <= 1'b0;
                        state    <= SEND_HI;
                    end
                end
                SEND_HI, SEND_LO: begin
                    if (!baud_wrap) begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end else begin
                        baud_cnt <= '0;
                        if (bit_cnt != 4'd9) begin
                            tx_shft <= {1'b1, tx_shft[8:1]};
                            TX      <= tx_shft[1];
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (state == SEND_HI) begin
                            // Low byte start bit follows the high stop bit directly
                            tx_shft <= {cmd_hold[7:0], 1'b0};
                            TX      <= 1'b0;
                            bit_cnt <= '0;
                            state   <= SEND_LO;
                        end else begin
                            tx_shft  <= '1;
                            TX       <= 1'b1;
                            bit_cnt  <= '0;
                            busy     <= 1'b0;
                            cmd_sent <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_shft <= '1;
                    TX      <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
